clock_step_controller: RTL and testbench
========================================

Name: clock_step_controller

Overview:
- Sequences the CPU datapath by generating a single-cycle clock-enable from the board oscillator.
- Implements the front-panel execution modes: free run, single micro-cycle step and single instruction step.
- Optionally halts on a breakpoint at an instruction boundary.
- Sits between the front-panel switches/button and the datapath's enable input; the datapath's registers advance only on cycles where o_cpuClkEn=1.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required before a step-button level is accepted (1 ms at 100 MHz).
- RUN_DIV, 1: in RUN, one enable per RUN_DIV oscillator cycles; must be >=1.

Ports:
- i_oszClk  in  1  oscillator clock; the only clock.
- i_btnReset  in  1  synchronous, active-high reset.
- i_btnStep  in  1  raw step button, 1=pressed; asynchronous and bouncing.
- i_swInstrNCycle  in  1  1=step whole instruction, 0=step one micro-cycle.
- i_swStepNRun  in  1  1=step mode, 0=run mode.
- i_swEnableBreakpoint  in  1  1=breakpoint halts enabled.
- i_instrDone  in  1  from control unit; 1 when the current micro-cycle is the last of its instruction.
- i_breakpoint  in  1  from datapath; 1 when the next instruction to execute is at a breakpoint address.
- o_cpuClkEn  out  1  registered datapath clock-enable pulse.
- o_halted  out  1  1 in HALT state.
- o_breakHit  out  1  sticky: last halt was caused by a breakpoint.
- o_state  out  2  current state, encoded as state_t.

Behaviour:
- Reset (i_btnReset=1 at a clock edge) sets the following; reset mid-operation aborts any pending step immediately:
  - state=HALT
  - o_cpuClkEn=0, o_breakHit=0, o_halted=1
  - synchronizer, debounce counter, debounced level and run divider all cleared.
- Step input conditioning:
  - 2-FF synchronizer.
  - Debounce counter resets whenever the synced value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - stepEvt is a 1-cycle pulse on a 0->1 transition of the debounced level. Release produces no event.
- Run tick: divider counts 0..RUN_DIV-1. tick=1 when count==RUN_DIV-1; it is always 1 when RUN_DIV=1. The divider free-runs only in RUN and is cleared otherwise.
- boundary = o_cpuClkEn & i_instrDone, i.e. an instruction completes on this enable.
- States (state_t: HALT=0, RUN=1, STEP_INSTR=2):
  - HALT:
    - If i_swStepNRun=0 and o_breakHit=0: go to RUN next cycle.
    - Else on stepEvt: clear o_breakHit. Then:
      - i_swStepNRun=0 -> RUN.
      - i_swInstrNCycle=0 -> stay HALT and assert o_cpuClkEn for exactly one cycle (the cycle after stepEvt).
      - otherwise -> STEP_INSTR.
  - RUN:
    - o_cpuClkEn follows the registered tick.
    - On boundary with i_swEnableBreakpoint & i_breakpoint: go to HALT and set o_breakHit.
    - Else on boundary with i_swStepNRun=1: go to HALT.
    - Switching to step mode therefore always completes the current instruction.
  - STEP_INSTR:
    - o_cpuClkEn=1 every cycle until boundary, then HALT.
    - Switch changes are ignored until completion.
    - Breakpoints are not checked; a step always executes exactly one instruction.
- Enable timing: o_cpuClkEn is registered. The first enable appears the cycle after entry to RUN/STEP_INSTR or after stepEvt.
- An instruction whose first micro-cycle already has i_instrDone=1 completes after 1 enable.
- Step events:
  - stepEvt in RUN or STEP_INSTR is ignored; no queueing.
  - stepEvt coincident with reset is discarded.
- Priority in RUN when breakpoint and mode switch coincide: breakpoint wins (o_breakHit=1).
- o_halted = (state==HALT) combinationally from the state register.

Decomposition:
- Shared package clock_ctrl_pkg holds:
  - typedef enum logic[1:0] state_t {HALT, RUN, STEP_INSTR}
  - localparam default DEBOUNCE_CYCLES
- One sub-module, button_debouncer (i_oszClk, i_btnReset, i_btn -> o_level, o_rise), parameterised by DEBOUNCE_CYCLES. It is reusable for the other front-panel buttons.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=1 unless stated):
- Reset with swStepNRun=1, then press step with swInstrNCycle=0 (held 10 cycles, bouncing 0/1 for the first 3 cycles) -> exactly one o_cpuClkEn pulse, 1 cycle wide; o_halted stays 1; a second clean press gives exactly one more pulse.
- swStepNRun=1, swInstrNCycle=1, instrDone asserted on every 3rd enable; one press -> exactly 3 consecutive enables, then o_halted=1 and o_state=HALT.
- swStepNRun=0 after reset -> RUN within 1 cycle; o_cpuClkEn=1 every cycle. With RUN_DIV=4 -> one enable every 4 cycles.
- RUN with breakpoint enabled; i_breakpoint=1 coincident with instrDone on an enable -> HALT, o_breakHit=1, no further enables. A press then resumes RUN, clears o_breakHit, and the next enable follows 1 cycle later.
- RUN, flip swStepNRun to 1 mid-instruction (2 micro-cycles left) -> 2 more enables, halt on the boundary; a step press during those cycles is ignored.
- Assert i_btnReset during STEP_INSTR -> next cycle o_cpuClkEn=0, o_state=HALT, o_breakHit=0; a held step button after reset yields no event until released and pressed again.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and defaults for the front-panel clock/step controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT       = 2'd0,
        RUN        = 2'd1,
        STEP_INSTR = 2'd2
    } state_t;

    // 1 ms of stable level at a 100 MHz oscillator
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;

endpackage

// File: rtl/clock_step_controller_debouncer.sv
// Front-panel button conditioner: 2-FF synchronizer, debounce counter,
// registered rising-edge pulse of the debounced level.
module button_debouncer
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_oszClk,
    input  logic i_btnReset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Two extra cycles cover the synchronizer flush after reset
    localparam int unsigned ARM_CYCLES = DEBOUNCE_CYCLES + 2;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             armed_q, armed_d;

    always_ff @(posedge i_oszClk) begin
        if (i_btnReset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        sync1_d   = i_btn;
        sync2_d   = sync1_q;
        cnt_d     = '0;
        level_d   = level_q;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;

        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A button held through reset must be seen released before it can fire
        if (!armed_q) begin
            if (sync2_q) begin
                arm_cnt_d = '0;
            end else if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
        end

        rise_d = armed_q & level_d & ~level_q;
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/clock_step_controller.sv
// Generates the datapath clock-enable for run, micro-step and instruction-step
// modes, with optional breakpoint halts at instruction boundaries.
module clock_step_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned RUN_DIV         = 1
) (
    input  logic       i_oszClk,
    input  logic       i_btnReset,
    input  logic       i_btnStep,
    input  logic       i_swInstrNCycle,
    input  logic       i_swStepNRun,
    input  logic       i_swEnableBreakpoint,
    input  logic       i_instrDone,
    input  logic       i_breakpoint,
    output logic       o_cpuClkEn,
    output logic       o_halted,
    output logic       o_breakHit,
    output logic [1:0] o_state
);

    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    state_t           state_q, state_d;
    logic             clk_en_q, clk_en_d;
    logic             break_hit_q, break_hit_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic step_evt;
    logic step_level_unused;
    logic tick_c;
    logic boundary_c;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .i_oszClk  (i_oszClk),
        .i_btnReset(i_btnReset),
        .i_btn     (i_btnStep),
        .o_level   (step_level_unused),
        .o_rise    (step_evt)
    );

    always_ff @(posedge i_oszClk) begin
        if (i_btnReset) begin
            state_q     <= HALT;
            clk_en_q    <= 1'b0;
            break_hit_q <= 1'b0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            break_hit_q <= break_hit_d;
            div_q       <= div_d;
        end
    end

    assign tick_c     = (div_q == DIV_W'(RUN_DIV - 1));
    assign boundary_c = clk_en_q & i_instrDone;

    always_comb begin
        state_d     = state_q;
        clk_en_d    = 1'b0;
        break_hit_d = break_hit_q;
        div_d       = '0;

        case (state_q)
            HALT: begin
                if (!i_swStepNRun && !break_hit_q) begin
                    state_d = RUN;
                end else if (step_evt) begin
                    break_hit_d = 1'b0;
                    if (!i_swStepNRun) begin
                        state_d = RUN;
                    end else if (!i_swInstrNCycle) begin
                        clk_en_d = 1'b1;
                    end else begin
                        state_d = STEP_INSTR;
                    end
                end
            end
            RUN: begin
                clk_en_d = tick_c;
                div_d    = tick_c ? '0 : div_q + DIV_W'(1);
                // Breakpoint outranks a coincident switch to step mode
                if (boundary_c && i_swEnableBreakpoint && i_breakpoint) begin
                    state_d     = HALT;
                    break_hit_d = 1'b1;
                    clk_en_d    = 1'b0;
                    div_d       = '0;
                end else if (boundary_c && i_swStepNRun) begin
                    state_d  = HALT;
                    clk_en_d = 1'b0;
                    div_d    = '0;
                end
            end
            STEP_INSTR: begin
                if (boundary_c) begin
                    state_d = HALT;
                end else begin
                    clk_en_d = 1'b1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign o_cpuClkEn = clk_en_q;
    assign o_breakHit = break_hit_q;
    assign o_halted   = (state_q == HALT);
    assign o_state    = state_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller: a cycle-exact vector table for
// micro-stepping plus hand sequences for run, instruction step, breakpoints and reset.
module tb_clock_step_controller;
    import clock_ctrl_pkg::*;

    localparam int unsigned DB   = 4;
    localparam int          NVEC = 48;

    logic       clk = 1'b0;
    logic       rst, btn, sw_instr, sw_step, sw_enbp, instr_done, bp;
    logic       o_cpuClkEn, o_halted, o_breakHit;
    logic [1:0] o_state;
    logic       o4_cpuClkEn, dut4_halted_unused, dut4_bh_unused;
    logic [1:0] o4_state;

    always #5 clk = ~clk;

    clock_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(1)) dut (
        .i_oszClk(clk), .i_btnReset(rst), .i_btnStep(btn),
        .i_swInstrNCycle(sw_instr), .i_swStepNRun(sw_step),
        .i_swEnableBreakpoint(sw_enbp), .i_instrDone(instr_done),
        .i_breakpoint(bp), .o_cpuClkEn(o_cpuClkEn), .o_halted(o_halted),
        .o_breakHit(o_breakHit), .o_state(o_state)
    );

    clock_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(4)) dut4 (
        .i_oszClk(clk), .i_btnReset(rst), .i_btnStep(btn),
        .i_swInstrNCycle(sw_instr), .i_swStepNRun(sw_step),
        .i_swEnableBreakpoint(sw_enbp), .i_instrDone(instr_done),
        .i_breakpoint(bp), .o_cpuClkEn(o4_cpuClkEn), .o_halted(dut4_halted_unused),
        .o_breakHit(dut4_bh_unused), .o_state(o4_state)
    );

    typedef struct {
        logic       rst;
        logic       btn;
        logic       en;
        logic       halted;
        logic [1:0] st;
        logic       bh;
    } vec_t;

    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    int en_cnt, en4_cnt, mc, instr_len, cyc_n, first_en, last_en;
    bit auto_done, en_prev, found;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock; samples outputs and models a datapath whose instructions are instr_len enables long
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (en_prev) mc = instr_done ? 0 : mc + 1;
        en_prev = o_cpuClkEn;
        if (o_cpuClkEn) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc_n;
            last_en = cyc_n;
        end
        if (o4_cpuClkEn) en4_cnt++;
        instr_done = auto_done && o_cpuClkEn && (mc >= instr_len - 1);
    endtask

    initial begin
        rst = 1'b0; btn = 1'b0; sw_instr = 1'b0; sw_step = 1'b1;
        sw_enbp = 1'b0; instr_done = 1'b0; bp = 1'b0;
        en_cnt = 0; en4_cnt = 0; mc = 0; instr_len = 3; cyc_n = 0;
        first_en = -1; last_en = -1; auto_done = 1'b0; en_prev = 1'b0; found = 1'b0;

        // Micro-step table: bouncing press, release, clean press, release
        for (int i = 0; i < NVEC; i++)
            vecs[i] = '{rst: 1'b0, btn: 1'b0, en: 1'b0, halted: 1'b1, st: 2'd0, bh: 1'b0};
        vecs[0].rst  = 1'b1;
        vecs[11].btn = 1'b1;
        vecs[13].btn = 1'b1;
        for (int i = 14; i <= 20; i++) vecs[i].btn = 1'b1;
        for (int i = 30; i <= 39; i++) vecs[i].btn = 1'b1;
        vecs[19].en = 1'b1;
        vecs[36].en = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst;
            btn = vecs[i].btn;
            @(negedge clk);
            check($sformatf("vec%0d{en,halted,state,bh}", i),
                  int'({o_cpuClkEn, o_halted, o_state, o_breakHit}),
                  int'({vecs[i].en, vecs[i].halted, vecs[i].st, vecs[i].bh}));
        end

        // Instruction step: three enables, then back to HALT
        sw_instr = 1'b1; auto_done = 1'b1; instr_len = 3; mc = 0; en_prev = 1'b0;
        en_cnt = 0; first_en = -1; last_en = -1;
        btn = 1'b1;
        repeat (10) cyc();
        btn = 1'b0;
        repeat (15) cyc();
        check("istep_enables", en_cnt, 3);
        check("istep_consecutive", last_en - first_en, 2);
        check("istep_halted", o_halted, 1);
        check("istep_state", o_state, int'(HALT));

        // Run mode from reset, RUN_DIV=1 and RUN_DIV=4
        auto_done = 1'b0; instr_done = 1'b0; sw_step = 1'b0;
        rst = 1'b1;
        cyc();
        check("run_reset_state", o_state, int'(HALT));
        check("run_reset_en", o_cpuClkEn, 0);
        rst = 1'b0; mc = 0; en_prev = 1'b0;
        cyc();
        check("run_entry_state", o_state, int'(RUN));
        check("run_div4_state", o4_state, int'(RUN));
        cyc();
        check("run_first_en", o_cpuClkEn, 1);
        en_cnt = 0; en4_cnt = 0;
        repeat (8) cyc();
        check("run_div1_count", en_cnt, 8);
        check("run_div4_count", en4_cnt, 2);

        // Breakpoint halt at an instruction boundary
        sw_enbp = 1'b1; bp = 1'b1; auto_done = 1'b1; instr_len = 3; mc = 0;
        for (int k = 0; k < 30 && !o_halted; k++) cyc();
        check("bp_halted", o_halted, 1);
        check("bp_hit", o_breakHit, 1);
        check("bp_state", o_state, int'(HALT));
        en_cnt = 0;
        repeat (5) cyc();
        check("bp_no_enables", en_cnt, 0);
        bp = 1'b0;
        btn = 1'b1;
        for (int k = 0; k < 20 && o_state != 2'(RUN); k++) cyc();
        check("bp_resume_state", o_state, int'(RUN));
        check("bp_resume_cleared", o_breakHit, 0);
        check("bp_resume_en_wait", o_cpuClkEn, 0);
        cyc();
        check("bp_resume_en", o_cpuClkEn, 1);
        repeat (3) cyc();
        btn = 1'b0;
        repeat (10) cyc();

        // Switch to step mode with two micro-cycles left; a press meanwhile is ignored
        sw_enbp = 1'b0; sw_instr = 1'b0; instr_len = 8;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cyc();
            found = o_cpuClkEn && instr_done;
        end
        check("sw_boundary_found", int'(found), 1);
        btn = 1'b1;
        repeat (6) cyc();
        sw_step = 1'b1;
        en_cnt = 0;
        repeat (4) cyc();
        btn = 1'b0;
        repeat (20) cyc();
        check("sw_remaining_enables", en_cnt, 2);
        check("sw_halted", o_halted, 1);
        check("sw_state", o_state, int'(HALT));

        // Reset during an instruction step; the held button must not fire afterwards
        sw_instr = 1'b1; auto_done = 1'b0; instr_done = 1'b0;
        btn = 1'b1;
        for (int k = 0; k < 20 && o_state != 2'(STEP_INSTR); k++) cyc();
        check("rst_in_step_state", o_state, int'(STEP_INSTR));
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_en", o_cpuClkEn, 0);
        check("rst_state", o_state, int'(HALT));
        check("rst_bh", o_breakHit, 0);
        mc = 0; en_prev = 1'b0; en_cnt = 0;
        repeat (20) cyc();
        check("rst_held_no_event", en_cnt, 0);
        btn = 1'b0;
        repeat (15) cyc();
        sw_instr = 1'b0;
        btn = 1'b1;
        repeat (10) cyc();
        btn = 1'b0;
        repeat (10) cyc();
        check("rst_repress_one_pulse", en_cnt, 1);
        check("rst_repress_halted", o_halted, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
